// File: rtl/adc_pkg.sv
// Shared constants for the serial ADC capture front end: FSM encodings and
// the AD7476-style frame layout (leading zeros followed by MSB-first data).
package adc_pkg;

    // FSM state encodings, kept as plain constants for legacy compatibility
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCsSetup = 3'd1;
    localparam logic [2:0] StShift   = 3'd2;
    localparam logic [2:0] StDone    = 3'd3;
    localparam logic [2:0] StQuiet   = 3'd4;

    // Frame layout of the ADC
    localparam int unsigned AdcFrameBits = 16;
    localparam int unsigned AdcDataBits  = 12;
    localparam int unsigned AdcLeadBits  = AdcFrameBits - AdcDataBits;

endpackage

// File: rtl/sclk_tick_gen.sv
// SCLK half-period generator. While run_i is high the registered clock
// toggles every ClkDiv cycles; rise_o/fall_o flag the cycle whose closing
// edge ends a low/high half. park_i keeps the clock high at the end of a
// high half so the final period of a frame leaves SCLK idling high.
module sclk_tick_gen #(
    parameter int unsigned ClkDiv = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic park_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [7:0] DivLast = 8'(ClkDiv - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;
    logic       half_end;

    // Next-state for the half-period counter and the SCLK register
    always_comb begin
        half_end = run_i && (cnt_q == DivLast);
        cnt_d    = cnt_q;
        sclk_d   = sclk_q;
        if (!run_i) begin
            cnt_d  = 8'd0;
            sclk_d = 1'b1;
        end else if (half_end) begin
            cnt_d  = 8'd0;
            sclk_d = ~sclk_q | park_i;
        end else begin
            cnt_d  = cnt_q + 8'd1;
        end
    end

    // State registers; SCLK idles high out of reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 8'd0;
            sclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;
    assign rise_o = half_end && !sclk_q;
    assign fall_o = half_end && sclk_q;

endmodule

// File: rtl/spi_adc_capture.sv
// Drives one conversion frame of a 12-bit SPI ADC per accepted sample_req and
// presents the result in parallel on data_ad, with a valid strobe, a frame
// error strobe for nonzero leading bits and a sticky overrun flag.
module spi_adc_capture
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned FRAME_BITS   = AdcFrameBits,
    parameter int unsigned DATA_BITS    = AdcDataBits,
    parameter int unsigned QUIET_CYCLES = 4
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 sample_req,
    input  logic                 adc_sdata,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic [DATA_BITS-1:0] data_ad,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned        LeadBits  = FRAME_BITS - DATA_BITS;
    localparam int unsigned        BitCntW   = $clog2(FRAME_BITS) + 1;
    localparam logic [BitCntW-1:0] BitLast   = BitCntW'(FRAME_BITS - 1);
    localparam logic [7:0]         QuietLast = 8'(QUIET_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic                  sdata_q;
    logic                  rise_dly_q;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]            quiet_q, quiet_d;
    logic                  cs_n_q, cs_n_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  sclk_run, sclk_park;
    logic                  sclk_rise, sclk_fall;
    logic                  lead_ok;

    assign sclk_run  = (state_q == StCsSetup) || (state_q == StShift);
    assign sclk_park = (state_q == StShift) && (bit_cnt_q == BitLast);

    sclk_tick_gen #(
        .ClkDiv (CLK_DIV)
    ) u_sclk_tick_gen (
        .clk_i  (sysclk),
        .rst_ni (rst_n),
        .run_i  (sclk_run),
        .park_i (sclk_park),
        .sclk_o (adc_sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // Frame sequencing; the sample is shifted one cycle after SCLK rises so the
    // input register has already captured the bit the ADC drove on the fall
    always_comb begin
        shift_d   = rise_dly_q ? {shift_q[FRAME_BITS-2:0], sdata_q} : shift_q;
        lead_ok   = (shift_d[FRAME_BITS-1 -: LeadBits] == '0);
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        quiet_d   = quiet_q;
        cs_n_d    = cs_n_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (sample_req && enable) begin
                    state_d = StCsSetup;
                    cs_n_d  = 1'b0;
                end
            end
            StCsSetup: begin
                if (sclk_fall) begin
                    state_d   = StShift;
                    bit_cnt_d = '0;
                end
            end
            StShift: begin
                if (sclk_fall) begin
                    if (bit_cnt_q == BitLast) begin
                        // Flags are registered here so they show during DONE
                        state_d = StDone;
                        cs_n_d  = 1'b1;
                        if (lead_ok) begin
                            data_d  = shift_d[DATA_BITS-1:0];
                            valid_d = 1'b1;
                        end else begin
                            ferr_d  = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StQuiet;
                quiet_d = 8'd0;
            end
            StQuiet: begin
                if (quiet_q == QuietLast) begin
                    state_d = StIdle;
                end else begin
                    quiet_d = quiet_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    // Sticky overrun: set by a request that arrives while a frame is in flight
    always_comb begin
        ovr_d = ovr_q;
        if (!enable) begin
            ovr_d = 1'b0;
        end else if (sample_req && (state_q != StIdle)) begin
            ovr_d = 1'b1;
        end
    end

    // State registers; reset parks the ADC interface deselected
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sdata_q    <= 1'b0;
            rise_dly_q <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            quiet_q    <= 8'd0;
            cs_n_q     <= 1'b1;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sdata_q    <= adc_sdata;
            rise_dly_q <= sclk_rise;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            quiet_q    <= quiet_d;
            cs_n_q     <= cs_n_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign adc_cs_n   = cs_n_q;
    assign data_ad    = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_spi_adc_capture.sv
// Scoreboard bench for spi_adc_capture: three instances (CLK_DIV 2, 1, 5)
// each fed by a behavioural ADC that drives the next frame bit after every
// SCLK falling edge while chip select is low.
module tb_spi_adc_capture;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    logic        rst_n [3];
    logic        en    [3];
    logic        req   [3];
    logic        sdata [3];
    logic        cs_n  [3];
    logic        sclk  [3];
    logic [11:0] dad   [3];
    logic        dv    [3];
    logic        fe    [3];
    logic        bsy   [3];
    logic        ovr   [3];
    logic [15:0] word  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_adc_capture #(
            .CLK_DIV      ((g == 0) ? 2 : ((g == 1) ? 1 : 5)),
            .FRAME_BITS   (16),
            .DATA_BITS    (12),
            .QUIET_CYCLES (4)
        ) u_dut (
            .sysclk     (sysclk),
            .rst_n      (rst_n[g]),
            .enable     (en[g]),
            .sample_req (req[g]),
            .adc_sdata  (sdata[g]),
            .adc_cs_n   (cs_n[g]),
            .adc_sclk   (sclk[g]),
            .data_ad    (dad[g]),
            .data_valid (dv[g]),
            .frame_err  (fe[g]),
            .busy       (bsy[g]),
            .overrun    (ovr[g])
        );
    end

    typedef struct {
        int          g;
        logic        is_err;
        logic [11:0] data;
        int          at;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC model: next bit appears half a sysclk after each SCLK fall
    int   idx    [3];
    logic sclk_m [3];
    always @(negedge sysclk) begin
        for (int g = 0; g < 3; g++) begin
            if (cs_n[g] !== 1'b0) begin
                idx[g]    = 0;
                sclk_m[g] = 1'b1;
                sdata[g]  = 1'b0;
            end else begin
                if (sclk_m[g] && !sclk[g] && idx[g] < 16) begin
                    sdata[g] = word[g][15 - idx[g]];
                    idx[g]++;
                end
                sclk_m[g] = sclk[g];
            end
        end
    end

    // Frame shape statistics: cs_n low length, SCLK rises, half-period extremes
    int   cs_low [3] = '{default: 0};
    int   rises  [3] = '{default: 0};
    int   hmin   [3] = '{default: 0};
    int   hmax   [3] = '{default: 0};
    int   run    [3] = '{default: 0};
    int   bfall  [3] = '{default: 0};
    logic cs_p   [3] = '{default: 1'b1};
    logic sclk_p [3] = '{default: 1'b1};
    logic busy_p [3] = '{default: 1'b0};
    always @(negedge sysclk) begin
        for (int g = 0; g < 3; g++) begin
            if (cs_n[g] === 1'b0) begin
                if (cs_p[g]) begin
                    cs_low[g] = 0;
                    rises[g]  = 0;
                    hmin[g]   = 1000;
                    hmax[g]   = 0;
                    run[g]    = 0;
                end
                cs_low[g]++;
                if (sclk[g] !== sclk_p[g]) begin
                    if (run[g] > 0) begin
                        if (run[g] < hmin[g]) hmin[g] = run[g];
                        if (run[g] > hmax[g]) hmax[g] = run[g];
                    end
                    if (sclk[g] === 1'b1) rises[g]++;
                    run[g] = 1;
                end else begin
                    run[g]++;
                end
            end else begin
                run[g] = 0;
            end
            if (busy_p[g] && bsy[g] === 1'b0) bfall[g] = cyc;
            cs_p[g]   = (cs_n[g] !== 1'b0);
            sclk_p[g] = sclk[g];
            busy_p[g] = (bsy[g] === 1'b1);
        end
    end

    // Monitor: every valid or error strobe must match the next expectation
    always @(negedge sysclk) begin
        for (int g = 0; g < 3; g++) begin
            if (dv[g] === 1'b1 || fe[g] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", {30'd0, dv[g], fe[g]}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_inst", g, e.g);
                    chk("sb_kind", {30'd0, dv[g], fe[g]}, e.is_err ? 32'd1 : 32'd2);
                    chk("sb_data", {20'd0, dad[g]}, {20'd0, e.data});
                    chk("sb_cycle", cyc, e.at);
                end
            end
        end
    end

    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic pulse(input int g, input int c);
        to_cycle(c);
        req[g] = 1'b1;
        @(posedge sysclk);
        #1;
        req[g] = 1'b0;
    endtask

    task automatic expect_at(input int g, input logic is_err, input logic [11:0] d,
                             input int at);
        exp_t e;
        e.g      = g;
        e.is_err = is_err;
        e.data   = d;
        e.at     = at;
        sb_q.push_back(e);
    endtask

    initial begin
        int c0;
        for (int g = 0; g < 3; g++) begin
            rst_n[g] = 1'b0;
            en[g]    = 1'b0;
            req[g]   = 1'b0;
            word[g]  = 16'h0000;
        end
        @(posedge sysclk);
        #1;
        to_cycle(3);
        chk("rst_cs_n", cs_n[0], 1);
        chk("rst_sclk", sclk[0], 1);
        chk("rst_data_ad", dad[0], 0);
        chk("rst_valid", dv[0], 0);
        chk("rst_ferr", fe[0], 0);
        chk("rst_busy", bsy[0], 0);
        chk("rst_overrun", ovr[0], 0);
        for (int g = 0; g < 3; g++) begin
            rst_n[g] = 1'b1;
            en[g]    = 1'b1;
        end

        // Basic frame
        c0 = 10;
        word[0] = 16'h0ABC;
        expect_at(0, 1'b0, 12'hABC, c0 + 67);
        pulse(0, c0);
        to_cycle(c0 + 75);
        chk("basic_cs_low", cs_low[0], 66);
        chk("basic_rises", rises[0], 16);
        chk("basic_half_min", hmin[0], 2);
        chk("basic_half_max", hmax[0], 2);
        chk("basic_busy_fall", bfall[0], c0 + 72);
        chk("basic_data_ad", dad[0], 12'hABC);
        chk("basic_overrun", ovr[0], 0);

        // Leading-bit error keeps the previous sample
        c0 = 100;
        word[0] = 16'h8123;
        expect_at(0, 1'b1, 12'hABC, c0 + 67);
        pulse(0, c0);
        to_cycle(c0 + 75);
        chk("err_data_held", dad[0], 12'hABC);

        // Overrun mid-frame, sticky, then cleared by enable low
        c0 = 200;
        word[0] = 16'h0555;
        expect_at(0, 1'b0, 12'h555, c0 + 67);
        pulse(0, c0);
        pulse(0, c0 + 30);
        to_cycle(c0 + 75);
        chk("ovr_set", ovr[0], 1);
        to_cycle(c0 + 85);
        chk("ovr_sticky", ovr[0], 1);
        chk("ovr_no_restart", bsy[0], 0);
        en[0]  = 1'b0;
        req[0] = 1'b1;
        @(posedge sysclk);
        #1;
        en[0]  = 1'b1;
        req[0] = 1'b0;
        chk("ovr_cleared", ovr[0], 0);
        chk("dis_req_no_start", bsy[0], 0);

        // Request on the final QUIET cycle is ignored
        c0 = 300;
        word[0] = 16'h0246;
        expect_at(0, 1'b0, 12'h246, c0 + 67);
        pulse(0, c0);
        pulse(0, c0 + 71);
        to_cycle(c0 + 74);
        chk("qend_busy", bsy[0], 0);
        chk("qend_ovr", ovr[0], 1);
        chk("qend_busy_fall", bfall[0], c0 + 72);
        to_cycle(c0 + 80);
        en[0] = 1'b0;
        @(posedge sysclk);
        #1;
        en[0] = 1'b1;
        chk("qend_ovr_cleared", ovr[0], 0);

        // Back-to-back at the minimum spacing
        c0 = 400;
        word[0] = 16'h0001;
        expect_at(0, 1'b0, 12'h001, c0 + 67);
        pulse(0, c0);
        to_cycle(c0 + 70);
        word[0] = 16'h0FFF;
        expect_at(0, 1'b0, 12'hFFF, c0 + 72 + 67);
        pulse(0, c0 + 72);
        to_cycle(c0 + 72 + 75);
        chk("b2b_overrun", ovr[0], 0);
        chk("b2b_data_ad", dad[0], 12'hFFF);

        // Asynchronous reset mid-frame
        c0 = 600;
        word[0] = 16'h0777;
        pulse(0, c0);
        to_cycle(c0 + 20);
        chk("pre_rst_cs_n", cs_n[0], 0);
        chk("pre_rst_sclk", sclk[0], 0);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("arst_cs_n", cs_n[0], 1);
        chk("arst_sclk", sclk[0], 1);
        chk("arst_data_ad", dad[0], 0);
        chk("arst_busy", bsy[0], 0);
        to_cycle(c0 + 23);
        rst_n[0] = 1'b1;
        to_cycle(c0 + 30);
        word[0] = 16'h0321;
        expect_at(0, 1'b0, 12'h321, c0 + 30 + 67);
        pulse(0, c0 + 30);
        to_cycle(c0 + 30 + 75);
        chk("arst_recover_data", dad[0], 12'h321);

        // CLK_DIV = 1
        c0 = 800;
        word[1] = 16'h0A5A;
        expect_at(1, 1'b0, 12'hA5A, c0 + 34);
        pulse(1, c0);
        to_cycle(c0 + 45);
        chk("div1_cs_low", cs_low[1], 33);
        chk("div1_rises", rises[1], 16);
        chk("div1_half_min", hmin[1], 1);
        chk("div1_half_max", hmax[1], 1);
        chk("div1_busy_fall", bfall[1], c0 + 39);

        // CLK_DIV = 5, with enable dropped mid-frame
        c0 = 900;
        word[2] = 16'h05A5;
        expect_at(2, 1'b0, 12'h5A5, c0 + 166);
        pulse(2, c0);
        to_cycle(c0 + 50);
        en[2] = 1'b0;
        to_cycle(c0 + 180);
        chk("div5_cs_low", cs_low[2], 165);
        chk("div5_rises", rises[2], 16);
        chk("div5_half_min", hmin[2], 5);
        chk("div5_half_max", hmax[2], 5);
        chk("div5_busy_fall", bfall[2], c0 + 171);
        chk("div5_data_ad", dad[2], 12'h5A5);
        en[2] = 1'b1;

        to_cycle(c0 + 190);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL sb_missing: inst %0d got no strobe, expected data 0x%0h at cycle %0d",
                     e.g, e.data, e.at);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_adc_capture.md
Name: spi_adc_capture

Overview:
- Front-end stage that drives a 12-bit serial SPI ADC (AD7476-class: 4 leading zeros followed by 12 data bits, MSB first) and delivers parallel samples on data_ad.
- Sits directly upstream of the sample-packing/UART-send stage.
- One conversion frame runs per sample_req pulse; sample_req is the divider's ad_clk rising edge, edge-detected by the consumer's clock domain (sysclk).
- The result is held on data_ad until the next good frame; data_valid marks each new sample.

Parameters:
- CLK_DIV, 2: sysclk cycles per SCLK half-period (50 MHz / (2*2) = 12.5 MHz SCLK); legal range 1..255.
- FRAME_BITS, 16: SCLK rising edges per frame.
- DATA_BITS, 12: data bits at the end of the frame; leading bits = FRAME_BITS - DATA_BITS.
- QUIET_CYCLES, 4: minimum sysclk cycles with cs_n high between frames; legal range 1..255.

Ports:
- sysclk  in  1  system clock, 50 MHz; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; when low, new requests are not accepted.
- sample_req  in  1  single-cycle start pulse.
- adc_sdata  in  1  serial data from the ADC; registered once before use.
- adc_cs_n  out  1  ADC chip select, active-low.
- adc_sclk  out  1  ADC serial clock; idles high.
- data_ad  out  DATA_BITS  last good sample, held stable between updates.
- data_valid  out  1  one-cycle pulse when data_ad updates.
- frame_err  out  1  one-cycle pulse when a leading bit was nonzero.
- busy  out  1  high from request acceptance until QUIET ends.
- overrun  out  1  sticky; set by a sample_req ignored while busy; cleared while enable=0.

Behaviour:
- Reset values: adc_cs_n=1, adc_sclk=1, data_ad=0, data_valid=0, frame_err=0, busy=0, overrun=0, state=IDLE.
- Reset is asynchronous. Asserting rst_n mid-frame forces adc_cs_n and adc_sclk high immediately and discards the partial frame.
- States: IDLE, CS_SETUP, SHIFT, DONE, QUIET.
- IDLE:
  - Accepts a request only when sample_req=1 and enable=1.
  - On acceptance: next cycle adc_cs_n=0, busy=1, go to CS_SETUP.
- CS_SETUP:
  - Holds adc_sclk=1 for CLK_DIV cycles, then goes to SHIFT.
- SHIFT:
  - Runs FRAME_BITS SCLK periods. Each period is adc_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - The registered adc_sdata is shifted in (MSB first) on the sysclk cycle where adc_sclk goes low to high.
  - A bit counter counts 0..FRAME_BITS-1. After the last high half-period, go to DONE.
- DONE (1 cycle):
  - adc_cs_n=1.
  - If the leading bits are all 0: data_ad <= low DATA_BITS of the shift register, data_valid=1.
  - Otherwise: frame_err=1 and data_ad is unchanged.
  - Then go to QUIET.
- QUIET:
  - adc_cs_n stays high for QUIET_CYCLES cycles, then IDLE.
  - busy drops on the cycle the state enters IDLE.
- Latency: the sample_req cycle is counted as cycle 0. The data_valid cycle is 1 + CLK_DIV + 2*CLK_DIV*FRAME_BITS, i.e. 67 at defaults.
- sample_req while busy: ignored and sets overrun. The in-flight frame is unaffected.
- sample_req on the same cycle QUIET finishes: ignored (state is still QUIET), sets overrun.
- enable deasserted mid-frame: the current frame completes normally, including data_valid.
- enable=0: overrun clears to 0. A sample_req with enable=0 neither starts a frame nor sets overrun.
- adc_sclk changes only from a register output; it is never derived combinationally.
- Widths: bit counter is clog2(FRAME_BITS)+1 bits; half-period counter is 8 bits; quiet counter is 8 bits.

Decomposition:
- Shared package (adc_pkg): state encodings (IDLE=0, CS_SETUP=1, SHIFT=2, DONE=3, QUIET=4) and the ADC frame constants FRAME_BITS=16, DATA_BITS=12, LEAD_BITS=4.
- One sub-module, sclk_tick_gen:
  - Half-period counter that issues rise/fall ticks while its run input is high.
  - Holds its output high when run is low.
- The top level holds the FSM, the input register, the shift register and the flags.

Test Plan:
- Basic frame:
  - Stimulus: ADC model serves 0x0ABC (16-bit frame), one sample_req.
  - Required: adc_cs_n low for 66 cycles, exactly 16 SCLK rising edges, data_ad=12'hABC with data_valid pulse at cycle 67, busy low at cycle 72.
- Leading-bit error:
  - Stimulus: model serves 0x8123.
  - Required: frame_err pulses once, data_valid stays 0, data_ad keeps the prior 12'hABC.
- Overrun:
  - Stimulus: second sample_req at cycle 30 of a frame.
  - Required: ignored, overrun=1 and sticky, first frame result correct.
  - Then drop enable for 1 cycle: overrun returns to 0.
- Back-to-back:
  - Stimulus: requests spaced exactly 72 cycles apart, data 0x0001 then 0x0FFF.
  - Required: both accepted, data_ad = 12'h001 then 12'hFFF, overrun=0.
- Reset mid-frame:
  - Stimulus: rst_n low at cycle 20 of a frame.
  - Required: adc_cs_n=1 and adc_sclk=1 asynchronously, data_ad=0, no data_valid; the next request after release yields the correct sample.
- Divider sweep:
  - Stimulus: CLK_DIV=1, then CLK_DIV=5.
  - Required: data_valid at cycles 34 and 166 respectively; SCLK half-periods exactly 1 and 5 cycles.
